// File: rtl/ysyx_23060124_axil_sram_if.sv
// rtl/ysyx_23060124_axil_sram_if.sv - AXI4-Lite signal bundle between CPU master and SRAM responder
interface ysyx_23060124_axil_sram_if;
  logic [31:0] S_AXI_AWADDR;
  logic        S_AXI_AWVALID;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic        S_AXI_WVALID;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY;
  logic [31:0] S_AXI_ARADDR;
  logic        S_AXI_ARVALID;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
  );
endinterface

// File: rtl/ysyx_23060124_axil_sram.sv
// rtl/ysyx_23060124_axil_sram.sv - AXI4-Lite responder SRAM with fixed read/write latency
// Independent read and write FSMs; out-of-range accesses answer DECERR and never touch the array.
module ysyx_23060124_axil_sram #(
  parameter logic [31:0] BASE   = 32'h8000_0000,
  parameter int          AW_W   = 12,
  parameter int          RD_LAT = 1,
  parameter int          WR_LAT = 1
) (
  input logic                      S_AXI_ACLK,
  input logic                      S_AXI_ARESET,
  ysyx_23060124_axil_sram_if.slave s_axi
);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_DECERR = 2'b11;
  localparam logic [32:0] SPAN        = 33'd4 << AW_W;

  typedef enum logic [1:0] {RIDLE, RWAIT, RRESP} r_state_t;
  typedef enum logic [1:0] {WIDLE, WWAIT, WRESP} w_state_t;

  logic [31:0] mem [0:(1<<AW_W)-1];

  r_state_t    r_state, r_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr, r_off, r_data;
  logic [1:0]  r_resp;
  logic        r_hit, ar_hs;

  w_state_t    w_state, w_next;
  logic [3:0]  w_cnt;
  logic [31:0] w_addr, w_off, w_data;
  logic [3:0]  w_strb;
  logic [1:0]  b_resp;
  logic        w_hit, aw_held, w_held, aw_hs, w_hs, aw_got, w_got;
  logic        unused_low;

  // An address below BASE wraps to a huge offset, so one unsigned compare covers both bounds.
  assign r_off      = r_addr - BASE;
  assign w_off      = w_addr - BASE;
  assign r_hit      = {1'b0, r_off} < SPAN;
  assign w_hit      = {1'b0, w_off} < SPAN;
  assign unused_low = ^{r_off[1:0], w_off[1:0]};

  assign s_axi.S_AXI_ARREADY = (r_state == RIDLE);
  assign s_axi.S_AXI_RVALID  = (r_state == RRESP);
  assign s_axi.S_AXI_RDATA   = r_data;
  assign s_axi.S_AXI_RRESP   = r_resp;
  assign s_axi.S_AXI_AWREADY = (w_state == WIDLE) && !aw_held;
  assign s_axi.S_AXI_WREADY  = (w_state == WIDLE) && !w_held;
  assign s_axi.S_AXI_BVALID  = (w_state == WRESP);
  assign s_axi.S_AXI_BRESP   = b_resp;

  assign ar_hs  = s_axi.S_AXI_ARVALID && s_axi.S_AXI_ARREADY;
  assign aw_hs  = s_axi.S_AXI_AWVALID && s_axi.S_AXI_AWREADY;
  assign w_hs   = s_axi.S_AXI_WVALID && s_axi.S_AXI_WREADY;
  assign aw_got = aw_held || aw_hs;
  assign w_got  = w_held || w_hs;

  always_comb begin
    r_next = r_state;
    case (r_state)
      RIDLE:   if (ar_hs) r_next = RWAIT;
      RWAIT:   if (r_cnt == 4'd0) r_next = RRESP;
      RRESP:   if (s_axi.S_AXI_RREADY) r_next = RIDLE;
      default: r_next = RIDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      r_state <= RIDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
      r_resp  <= RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (r_state == RIDLE && ar_hs) begin
        r_addr <= s_axi.S_AXI_ARADDR;
        r_cnt  <= 4'(RD_LAT);
      end else if (r_state == RWAIT) begin
        if (r_cnt == 4'd0) begin
          r_data <= r_hit ? mem[r_off[AW_W+1:2]] : 32'd0;
          r_resp <= r_hit ? RESP_OKAY : RESP_DECERR;
        end else begin
          r_cnt <= r_cnt - 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      WIDLE:   if (aw_got && w_got) w_next = WWAIT;
      WWAIT:   if (w_cnt == 4'd0) w_next = WRESP;
      WRESP:   if (s_axi.S_AXI_BREADY) w_next = WIDLE;
      default: w_next = WIDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
    if (S_AXI_ARESET) begin
      w_state <= WIDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      w_addr  <= 32'd0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      w_cnt   <= 4'd0;
      b_resp  <= RESP_OKAY;
    end else begin
      w_state <= w_next;
      case (w_state)
        WIDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            w_addr  <= s_axi.S_AXI_AWADDR;
          end
          if (w_hs) begin
            w_held <= 1'b1;
            w_data <= s_axi.S_AXI_WDATA;
            w_strb <= s_axi.S_AXI_WSTRB;
          end
          if (aw_got && w_got) w_cnt <= 4'(WR_LAT);
        end
        WWAIT: begin
          if (w_cnt == 4'd0) b_resp <= w_hit ? RESP_OKAY : RESP_DECERR;
          else               w_cnt  <= w_cnt - 4'd1;
        end
        WRESP: begin
          if (s_axi.S_AXI_BREADY) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Commit shares the edge with the read sample, so a coincident read still sees the old word.
  always_ff @(posedge S_AXI_ACLK) begin
    if (w_state == WWAIT && w_cnt == 4'd0 && w_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (w_strb[i]) mem[w_off[AW_W+1:2]][8*i +: 8] <= w_data[8*i +: 8];
      end
    end
  end
endmodule

// File: tb/tb_ysyx_23060124_axil_sram.sv
// tb/tb_ysyx_23060124_axil_sram.sv - self-checking bench for the AXI4-Lite SRAM responder
module tb_ysyx_23060124_axil_sram;
  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam int          AW_W   = 12;
  localparam int          RD_LAT = 2;
  localparam int          WR_LAT = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ysyx_23060124_axil_sram_if bus();

  ysyx_23060124_axil_sram #(.BASE(BASE), .AW_W(AW_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .S_AXI_ACLK  (clk),
    .S_AXI_ARESET(rst),
    .s_axi       (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit          do_wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [1:0]  exp_bresp;
    logic [31:0] raddr;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
  } vec_t;

  vec_t        vecs [11];
  logic [31:0] ref_mem [int];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic bit model_hit(input logic [31:0] a);
    longint la, lb;
    la = longint'(a);
    lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * (longint'(1) << AW_W));
  endfunction

  function automatic int model_idx(input logic [31:0] a);
    return int'((longint'(a) - longint'(BASE)) / 4);
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input logic [1:0] exp_resp, input int aw_dly, input int w_dly,
                          input int b_dly, input string nm);
    bit aw_done = 0, w_done = 0, hs_aw, hs_w;
    int cyc = 0, n = 0;
    bus.S_AXI_AWADDR = a;
    bus.S_AXI_WDATA  = d;
    bus.S_AXI_WSTRB  = s;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (!aw_done && cyc >= aw_dly) bus.S_AXI_AWVALID = 1'b1;
      if (!w_done && cyc >= w_dly)   bus.S_AXI_WVALID  = 1'b1;
      hs_aw = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      hs_w  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      tick();
      cyc++;
      if (hs_aw) begin aw_done = 1; bus.S_AXI_AWVALID = 1'b0; end
      if (hs_w)  begin w_done = 1;  bus.S_AXI_WVALID  = 1'b0; end
    end
    if (!(aw_done && w_done)) begin
      chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      bus.S_AXI_AWVALID = 1'b0;
      bus.S_AXI_WVALID  = 1'b0;
      return;
    end
    while (!bus.S_AXI_BVALID && n < 50) begin tick(); n++; end
    if (!bus.S_AXI_BVALID) begin
      chk({nm, "_bvalid_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({nm, "_blat"}, n, WR_LAT + 1);
    chk({nm, "_bresp"}, 32'(bus.S_AXI_BRESP), 32'(exp_resp));
    for (int i = 0; i < b_dly; i++) begin
      tick();
      chk({nm, "_bhold"}, {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b100);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    chk({nm, "_bdone"}, {bus.S_AXI_BVALID, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b011);
  endtask

  task automatic do_read(input logic [31:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int r_dly, input string nm);
    bit done = 0, hs;
    int cyc = 0, n = 0;
    bus.S_AXI_ARADDR  = a;
    bus.S_AXI_ARVALID = 1'b1;
    while (!done && cyc < 50) begin
      hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      tick();
      cyc++;
      if (hs) done = 1;
    end
    bus.S_AXI_ARVALID = 1'b0;
    if (!done) begin
      chk({nm, "_ar_timeout"}, 32'd0, 32'd1);
      return;
    end
    while (!bus.S_AXI_RVALID && n < 50) begin tick(); n++; end
    if (!bus.S_AXI_RVALID) begin
      chk({nm, "_rvalid_timeout"}, 32'd0, 32'd1);
      return;
    end
    chk({nm, "_rlat"}, n, RD_LAT + 1);
    chk({nm, "_rdata"}, bus.S_AXI_RDATA, exp_data);
    chk({nm, "_rresp"}, 32'(bus.S_AXI_RRESP), 32'(exp_resp));
    for (int i = 0; i < r_dly; i++) begin
      tick();
      chk({nm, "_rhold"}, {bus.S_AXI_RVALID, bus.S_AXI_ARREADY, bus.S_AXI_RRESP, bus.S_AXI_RDATA},
          {1'b1, 1'b0, exp_resp, exp_data});
    end
    bus.S_AXI_RREADY = 1'b1;
    tick();
    bus.S_AXI_RREADY = 1'b0;
    chk({nm, "_rdone"}, {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, 2'b01);
  endtask

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] w;
    if (!model_hit(a)) return;
    w = ref_mem.exists(model_idx(a)) ? ref_mem[model_idx(a)] : 32'd0;
    for (int i = 0; i < 4; i++) if (s[i]) w[8*i +: 8] = d[8*i +: 8];
    ref_mem[model_idx(a)] = w;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d, got;
    logic [3:0]  s;
    bit          seen;

    vecs[0]  = '{1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 32'h8000_0010, 32'hDEAD_BEEF, 2'b00};
    vecs[1]  = '{1'b1, 32'h8000_0010, 32'h1122_3344, 4'h5, 2'b00, 32'h8000_0010, 32'hDE22_BE44, 2'b00};
    vecs[2]  = '{1'b1, 32'h8000_0013, 32'hAABB_CCDD, 4'h0, 2'b00, 32'h8000_0012, 32'hDE22_BE44, 2'b00};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'h0102_0304, 4'hF, 2'b00, 32'h8000_0000, 32'h0102_0304, 2'b00};
    vecs[4]  = '{1'b1, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h8000_3FFF, 32'hCAFE_F00D, 2'b00};
    vecs[5]  = '{1'b1, 32'h8000_4000, 32'h1234_5678, 4'hF, 2'b11, 32'h8000_4000, 32'h0000_0000, 2'b11};
    vecs[6]  = '{1'b1, 32'h7FFF_FFFC, 32'h5555_5555, 4'hF, 2'b11, 32'h7FFF_FFFC, 32'h0000_0000, 2'b11};
    vecs[7]  = '{1'b1, 32'h8000_0010, 32'hFFFF_FFFF, 4'h8, 2'b00, 32'h8000_0010, 32'hFF22_BE44, 2'b00};
    vecs[8]  = '{1'b1, 32'h8000_0000, 32'h0000_0000, 4'h2, 2'b00, 32'h8000_0000, 32'h0102_0004, 2'b00};
    vecs[9]  = '{1'b0, 32'h0,         32'h0,         4'h0, 2'b00, 32'h8000_3FFC, 32'hCAFE_F00D, 2'b00};
    vecs[10] = '{1'b0, 32'h0,         32'h0,         4'h0, 2'b00, 32'hFFFF_FFFF, 32'h0000_0000, 2'b11};

    rst = 1'b1;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB   = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_RREADY = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b111);
    chk("reset_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    chk("reset_rdata", bus.S_AXI_RDATA, 32'd0);
    chk("reset_resp", {bus.S_AXI_RRESP, bus.S_AXI_BRESP}, 4'b0000);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].do_wr)
        do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].exp_bresp,
                 i % 3, (i + 1) % 3, i % 2, $sformatf("vec%0d_wr", i));
      do_read(vecs[i].raddr, vecs[i].exp_rdata, vecs[i].exp_rresp, i % 3, $sformatf("vec%0d_rd", i));
    end

    // W leads AW by three cycles
    bus.S_AXI_WDATA = 32'h0BAD_F00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_WVALID = 1'b0;
    chk("wfirst_ready", {bus.S_AXI_WREADY, bus.S_AXI_AWREADY}, 2'b01);
    tick(); tick();
    chk("wfirst_wait", {bus.S_AXI_WREADY, bus.S_AXI_AWREADY, bus.S_AXI_BVALID}, 3'b010);
    bus.S_AXI_AWADDR = 32'h8000_0030; bus.S_AXI_AWVALID = 1'b1;
    tick();
    bus.S_AXI_AWVALID = 1'b0;
    chk("wfirst_aw_drop", {bus.S_AXI_WREADY, bus.S_AXI_AWREADY}, 2'b00);
    begin
      int n = 0;
      while (!bus.S_AXI_BVALID && n < 50) begin tick(); n++; end
      chk("wfirst_blat", n, WR_LAT + 1);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick();
    bus.S_AXI_BREADY = 1'b0;
    seen = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (bus.S_AXI_BVALID) seen = 1; end
    chk("wfirst_single_b", 32'(seen), 32'd0);
    do_read(32'h8000_0030, 32'h0BAD_F00D, 2'b00, 0, "wfirst_rd");

    do_read(32'h8000_0010, 32'hFF22_BE44, 2'b00, 5, "rhold5");

    // Read sample lands on the write-commit edge -> old data; one edge later -> new data
    do_write(32'h8000_0040, 32'h1111_1111, 4'hF, 2'b00, 0, 0, 0, "haz_pre");
    for (int k = 0; k < 2; k++) begin
      bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
      bus.S_AXI_ARADDR = 32'h8000_0040; bus.S_AXI_ARVALID = 1'b1;
      bus.S_AXI_AWADDR = 32'h8000_0040;
      bus.S_AXI_WDATA  = (k == 0) ? 32'h2222_2222 : 32'h3333_3333;
      bus.S_AXI_WSTRB  = 4'hF;
      if (k == 1) begin bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; end
      tick();
      bus.S_AXI_ARVALID = 1'b0;
      if (k == 0) begin
        for (int i = 1; i < RD_LAT - WR_LAT; i++) tick();
        bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1;
        tick();
      end
      bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
      seen = 0; got = 32'hX;
      for (int i = 0; i < 20; i++) begin
        if (bus.S_AXI_RVALID && !seen) begin seen = 1; got = bus.S_AXI_RDATA; end
        tick();
      end
      bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
      chk($sformatf("haz%0d_rvalid", k), 32'(seen), 32'd1);
      chk($sformatf("haz%0d_rdata", k), got, (k == 0) ? 32'h1111_1111 : 32'h3333_3333);
    end

    // Reset while both channels are waiting
    do_write(32'h8000_0050, 32'hA5A5_A5A5, 4'hF, 2'b00, 0, 0, 0, "rst_pre");
    bus.S_AXI_ARADDR = 32'h8000_0050; bus.S_AXI_ARVALID = 1'b1;
    bus.S_AXI_AWADDR = 32'h8000_0050; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA  = 32'h5A5A_5A5A; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    tick();
    bus.S_AXI_ARVALID = 1'b0; bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    chk("rst_mid_busy", {bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b000);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_ready", {bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_WREADY}, 3'b111);
    chk("rst_mid_valid", {bus.S_AXI_BVALID, bus.S_AXI_RVALID}, 2'b00);
    chk("rst_mid_rdata", bus.S_AXI_RDATA, 32'd0);
    chk("rst_mid_resp", {bus.S_AXI_RRESP, bus.S_AXI_BRESP}, 4'b0000);
    #1 rst = 1'b0;
    bus.S_AXI_RREADY = 1'b1; bus.S_AXI_BREADY = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (bus.S_AXI_BVALID || bus.S_AXI_RVALID) seen = 1; end
    bus.S_AXI_RREADY = 1'b0; bus.S_AXI_BREADY = 1'b0;
    chk("rst_no_resp", 32'(seen), 32'd0);
    do_read(32'h8000_0050, 32'hA5A5_A5A5, 2'b00, 0, "rst_word_kept");

    // Randomized traffic against the reference array
    for (int k = 0; k < 64; k++) begin
      a = BASE + 32'((64 + k) * 4);
      d = $urandom;
      do_write(a, d, 4'hF, 2'b00, $urandom_range(0, 2), $urandom_range(0, 2), 0, $sformatf("init%0d", k));
      model_write(a, d, 4'hF);
    end
    for (int k = 0; k < 80; k++) begin
      if ($urandom_range(0, 9) == 0)
        a = $urandom_range(0, 1) ? BASE - 32'(4 * $urandom_range(1, 8)) : BASE + 32'h4000 + 32'(4 * $urandom_range(0, 8));
      else
        a = BASE + 32'((64 + $urandom_range(0, 63)) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, model_hit(a) ? 2'b00 : 2'b11, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2), $sformatf("rnd%0d_wr", k));
        model_write(a, d, s);
      end else begin
        do_read(a, model_hit(a) ? ref_mem[model_idx(a)] : 32'd0, model_hit(a) ? 2'b00 : 2'b11,
                $urandom_range(0, 2), $sformatf("rnd%0d_rd", k));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
